// File: rtl/pulse_msg_receiver.sv
// -----------------------------------------------------------------------------
// pulse_msg_receiver
//
// Purpose:
//   Receives pulse-width encoded messages on an asynchronous serial line.
//   Each bit is one high pulse followed by a low gap. A high longer than
//   ONE_THRESH clocks is a 1; otherwise it is a 0. After MSG_BITS bits the
//   assembled message is written into a first-word-fall-through FIFO.
//   The message is assembled MSB first.
//   If a high pulse saturates the pulse counter, or a low gap lasts
//   IDLE_TICKS clocks, the partial message is dropped and frame_error pulses.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   NEO_IN       in   asynchronous pulse-width encoded serial line
//   msg_valid    out  FIFO non-empty, head message presented on msg_data
//   msg_data     out  head message, MSB = first bit received
//   msg_ack      in   pops the head when msg_valid is high
//   msg_count    out  number of messages held
//   overflow     out  sticky: a complete message was dropped (FIFO full)
//   frame_error  out  one-cycle pulse: a partial message was discarded
//   busy         out  a message is in progress
// -----------------------------------------------------------------------------
module pulse_msg_receiver #(
    parameter int MSG_BITS   = 24,
    parameter int CNT_W      = 6,
    parameter int ONE_THRESH = 26,
    parameter int IDLE_TICKS = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          NEO_IN,
    output logic                          msg_valid,
    output logic [MSG_BITS-1:0]           msg_data,
    input  logic                          msg_ack,
    output logic [$clog2(FIFO_DEPTH):0]   msg_count,
    output logic                          overflow,
    output logic                          frame_error,
    output logic                          busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;
    localparam int BIT_W   = $clog2(MSG_BITS + 1);

    localparam logic [CNT_W-1:0]   CNT_SAT_PREV  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(ONE_THRESH);
    localparam logic [CNT_W-1:0]   CNT_IDLE_LAST = CNT_W'(IDLE_TICKS - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST      = BIT_W'(MSG_BITS - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL    = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_WAIT_LOW
    } state_t;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_sin;

    state_t                r_state;
    state_t                w_stateNext;
    logic [CNT_W-1:0]      r_pulseCnt;
    logic [CNT_W-1:0]      w_pulseNext;
    logic [BIT_W-1:0]      r_bitCnt;
    logic [BIT_W-1:0]      w_bitNext;
    logic [MSG_BITS-2:0]   r_shift;
    logic [MSG_BITS-2:0]   w_shiftNext;
    logic                  w_decoded;
    logic [MSG_BITS-1:0]   w_word;
    logic                  w_push;
    logic                  w_frameErr;

    logic                  r_pushPending;
    logic [MSG_BITS-1:0]   r_pushData;
    logic                  r_frameErr;

    logic [MSG_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [COUNT_W-1:0]    r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_accept;

    // Two-flop synchronizer; everything downstream decodes w_sin only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= NEO_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sin = r_sync2;

    // The pulse counter holds the number of line cycles seen at the current
    // level, including the edge cycle that caused the state change. That
    // makes a 27-clock high decode as a 1 and a 48-clock low time out.
    assign w_decoded = (r_pulseCnt > CNT_ONE);
    assign w_word    = {r_shift, w_decoded};

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        w_stateNext = r_state;
        w_pulseNext = r_pulseCnt;
        w_bitNext   = r_bitCnt;
        w_shiftNext = r_shift;
        w_push      = 1'b0;
        w_frameErr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sin) begin
                    w_stateNext = S_HIGH;
                    w_pulseNext = CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (w_sin) begin
                    // Counter would reach all-ones: treat as a stuck line.
                    if (r_pulseCnt == CNT_SAT_PREV) begin
                        w_frameErr  = 1'b1;
                        w_stateNext = S_WAIT_LOW;
                        w_pulseNext = '0;
                        w_bitNext   = '0;
                        w_shiftNext = '0;
                    end else begin
                        w_pulseNext = r_pulseCnt + CNT_W'(1);
                    end
                end else begin
                    w_pulseNext = CNT_W'(1);
                    if (r_bitCnt == BIT_LAST) begin
                        w_push      = 1'b1;
                        w_bitNext   = '0;
                        w_shiftNext = '0;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_shiftNext = w_word[MSG_BITS-2:0];
                        w_bitNext   = r_bitCnt + BIT_W'(1);
                        w_stateNext = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (w_sin) begin
                    w_stateNext = S_HIGH;
                    w_pulseNext = CNT_W'(1);
                end else if (r_pulseCnt == CNT_IDLE_LAST) begin
                    w_frameErr  = 1'b1;
                    w_stateNext = S_IDLE;
                    w_pulseNext = '0;
                    w_bitNext   = '0;
                    w_shiftNext = '0;
                end else begin
                    w_pulseNext = r_pulseCnt + CNT_W'(1);
                end
            end
            S_WAIT_LOW: begin
                if (!w_sin) begin
                    w_stateNext = S_IDLE;
                    w_pulseNext = '0;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_pulseNext = '0;
                w_bitNext   = '0;
                w_shiftNext = '0;
            end
        endcase
    end

    // FSM state and receive datapath registers. A completed message is
    // staged in r_pushData and written into the FIFO on the following edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pulseCnt    <= '0;
            r_bitCnt      <= '0;
            r_shift       <= '0;
            r_pushPending <= 1'b0;
            r_pushData    <= '0;
            r_frameErr    <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_pulseCnt    <= w_pulseNext;
            r_bitCnt      <= w_bitNext;
            r_shift       <= w_shiftNext;
            r_pushPending <= w_push;
            r_frameErr    <= w_frameErr;
            if (w_push) begin
                r_pushData <= w_word;
            end
        end
    end

    // A push is accepted when there is room, or when a pop frees a slot on
    // the same edge.
    assign w_full   = (r_count == COUNT_FULL);
    assign w_pop    = msg_valid && msg_ack;
    assign w_accept = r_pushPending && (!w_full || w_pop);

    // FIFO pointers, occupancy and the sticky overflow flag. Pointers are
    // PTR_W bits wide, so they wrap modulo FIFO_DEPTH by themselves.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + COUNT_W'(1);
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - COUNT_W'(1);
            end
            if (r_pushPending && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless while the FIFO is empty, so
    // the array is not reset.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_mem[r_wrPtr] <= r_pushData;
        end
    end

    assign msg_valid   = (r_count != '0);
    assign msg_data    = r_mem[r_rdPtr];
    assign msg_count   = r_count;
    assign overflow    = r_overflow;
    assign frame_error = r_frameErr;
    assign busy        = (r_state == S_HIGH) || (r_state == S_LOW);

endmodule

// File: doc/pulse_msg_receiver.md
PULSE_MSG_RECEIVER -- requirements
Module: pulse_msg_receiver

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- MSG_BITS, 24: bits per message.
- CNT_W, 6: width of the pulse-width counter.
- ONE_THRESH, 26: high-pulse length, in clocks, above which a bit decodes as 1.
- IDLE_TICKS, 48: low time, in clocks, that aborts a partial message.
- FIFO_DEPTH, 4: number of received messages held; must be a power of 2, at least 2.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- NEO_IN, in, 1: asynchronous serial line, pulse-width encoded.
- msg_valid, out, 1: FIFO non-empty; head message presented.
- msg_data, out, MSG_BITS: head message, MSB = first bit received.
- msg_ack, in, 1: pops the head when msg_valid is 1.
- msg_count, out, $clog2(FIFO_DEPTH)+1: messages held.
- overflow, out, 1: sticky; a complete message was dropped because the FIFO was full.
- frame_error, out, 1: one-cycle pulse; a partial message was discarded.
- busy, out, 1: a message is in progress (state HIGH or LOW).

Function
REQ-004 NEO_IN SHALL pass through a 2-flop synchronizer; all decode uses the synchronized signal (sin), adding 2 cycles of latency.
REQ-005 The FSM SHALL have four states: IDLE, HIGH, LOW, WAIT_LOW.
REQ-006 IDLE: on sin=1, go to HIGH with the pulse counter cleared, then count from 1 on the first HIGH cycle; otherwise stay in IDLE.
REQ-007 HIGH: the counter SHALL increment every cycle while sin=1.
REQ-008 HIGH, counter saturation: if the counter reaches 2^CNT_W-1 while sin=1, the block SHALL pulse frame_error, discard the partial message, and go to WAIT_LOW.
REQ-009 HIGH, falling edge (sin=0): the block SHALL decode bit = (counter > ONE_THRESH), shift it in at the LSB (left shift), increment the bit counter, clear the pulse counter and go to LOW.
REQ-010 When the bit just shifted is bit number MSG_BITS, the message is complete: it SHALL be pushed to the FIFO on the next clock edge, the bit counter SHALL clear, and the FSM SHALL go to IDLE instead of LOW.
REQ-011 LOW: the counter SHALL increment while sin=0; on sin=1, clear the counter and go to HIGH.
REQ-012 LOW, idle timeout: if the counter reaches IDLE_TICKS, the block SHALL pulse frame_error, clear the bit and shift counters, and go to IDLE.
REQ-013 WAIT_LOW: stay while sin=1; on sin=0 go to IDLE.
REQ-014 The FIFO SHALL be first-word-fall-through: msg_valid = (msg_count != 0), and msg_data = head whenever msg_valid is 1.
REQ-015 Pop SHALL occur when msg_valid && msg_ack; msg_ack while empty SHALL be ignored.
REQ-016 A push into an empty FIFO SHALL raise msg_valid on the cycle after the push edge.
REQ-017 A push while full with no pop SHALL drop the message and set overflow; FIFO contents SHALL be unchanged.
REQ-018 Simultaneous push and pop while full SHALL accept the push; msg_count SHALL be unchanged.
REQ-019 Simultaneous push and pop with count = 1 SHALL leave count at 1 with the new message at the head.
REQ-020 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 overflow SHALL stay set until reset.
REQ-022 frame_error SHALL be exactly one cycle wide per abort.

Reset
REQ-023 On reset=1 at a clock edge, the FSM SHALL go to IDLE and all counters, FIFO pointers and the shift register SHALL clear.
REQ-024 Outputs during and after reset SHALL be: msg_valid=0, msg_count=0, overflow=0, frame_error=0, busy=0; msg_data is don't-care while msg_valid=0.
REQ-025 Reset mid-message SHALL discard the partial message without a frame_error pulse; reset SHALL also clear stored messages and the synchronizer flops.

Verification
REQ-026 Single message, defaults: 24 bits of 0xA5C3F0 sent as 40-clock highs (1) and 12-clock highs (0), each followed by a 20-clock low -> msg_valid=1, msg_data=0xA5C3F0, msg_count=1; msg_ack for one cycle -> msg_valid=0.
REQ-027 Threshold: a high of exactly 26 clocks decodes as 0 and 27 clocks decodes as 1; check with 0x000001 sent using a final-bit high of 27 and all other highs of 26 -> msg_data=0x000001.
REQ-028 Overflow: 5 messages with no ack -> msg_count=4, overflow=1; 4 acks pop messages 1-4 in order, and message 5 is absent.
REQ-029 Full push+pop: FIFO full, msg_ack held during the push edge of a 5th message -> msg_count stays 4, overflow=0, and message 5 is present at the tail.
REQ-030 Abort paths: 10 bits then a 48-clock low -> one frame_error pulse, msg_count=0; NEO_IN held high 63 clocks -> frame_error, and no bit is decoded until NEO_IN goes low.
REQ-031 Reset mid-message after 12 bits, then a full message -> only the full message is received, with no frame_error pulse.
